// File: rtl/generic_sram_byte_en_clr.sv
// ---------------------------------------------------------------------------
// generic_sram_byte_en_clr
//   Single-port, byte-enabled synchronous SRAM with a built-in clear
//   sequencer. After reset, or on an i_clear pulse, every word is filled
//   with CLEAR_VALUE (one word per cycle) before requests are accepted.
//   Requests use a valid/ready handshake. Read latency is 1 or 2 cycles.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_req_valid     request present
//   o_req_ready     block can accept a request (low while clearing)
//   i_write_enable  1 = write, 0 = read
//   i_address       word address
//   i_write_data    write data
//   i_byte_enable   per-byte write mask, bit k covers bits [8k+7:8k]
//   i_clear         single-cycle pulse, starts a full clear
//   o_read_valid    one-cycle pulse per accepted read
//   o_read_data     read data, held between pulses
//   o_init_done     high once a clear has completed and none is running
// ---------------------------------------------------------------------------
module generic_sram_byte_en_clr #(
  parameter int                    DATA_WIDTH    = 128,
  parameter int                    ADDRESS_WIDTH = 7,
  parameter int                    READ_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_write_enable,
  input  logic [ADDRESS_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH-1:0]      i_write_data,
  input  logic [DATA_WIDTH/8-1:0]    i_byte_enable,
  input  logic                       i_clear,
  output logic                       o_read_valid,
  output logic [DATA_WIDTH-1:0]      o_read_data,
  output logic                       o_init_done
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int BE_W  = DATA_WIDTH / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // Counter is one bit wider than the address so the terminal count is
  // unambiguous and it never wraps back into the address range.
  localparam logic [ADDRESS_WIDTH:0] CLR_LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [0:0]             state_q, state_d;
  logic [ADDRESS_WIDTH:0] clr_cnt_q, clr_cnt_d;
  logic                   idle;
  logic                   wr_acc;
  logic                   rd_acc;

  assign idle        = (state_q == ST_IDLE);
  assign wr_acc      = idle && i_req_valid && i_write_enable;
  assign rd_acc      = idle && i_req_valid && !i_write_enable;
  assign o_req_ready = idle;
  assign o_init_done = idle;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        // i_clear is ignored here: a running clear is never restarted.
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
      end
      default: begin
        if (i_clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage: the clear sequencer owns the write port while clearing.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (!idle) begin
        mem[clr_cnt_q[ADDRESS_WIDTH-1:0]] <= CLEAR_VALUE;
      end else if (wr_acc) begin
        for (int k = 0; k < BE_W; k++) begin
          if (i_byte_enable[k]) mem[i_address][8*k +: 8] <= i_write_data[8*k +: 8];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  vld_p1, vld_p2;
      logic [DATA_WIDTH-1:0] rdata_p1, rdata_p2;

      // stage p1: registered array read
      always_ff @(posedge i_clk) begin
        if (i_rst) vld_p1 <= 1'b0;
        else       vld_p1 <= rd_acc;
      end

      always_ff @(posedge i_clk) begin
        if (rd_acc) rdata_p1 <= mem[i_address];
      end

      // stage p2: output register, holds between pulses
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          vld_p2   <= 1'b0;
          rdata_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) rdata_p2 <= rdata_p1;
        end
      end

      assign o_read_valid = vld_p2;
      assign o_read_data  = rdata_p2;
    end else begin : g_lat1
      logic                  vld_p1;
      logic [DATA_WIDTH-1:0] rdata_p1;

      // stage p1: registered array read drives the outputs directly
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          vld_p1   <= 1'b0;
          rdata_p1 <= '0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rdata_p1 <= mem[i_address];
        end
      end

      assign o_read_valid = vld_p1;
      assign o_read_data  = rdata_p1;
    end
  endgenerate

endmodule

// File: tb/tb_generic_sram_byte_en_clr.sv
module tb_generic_sram_byte_en_clr;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          LAT   = 2;
  localparam logic [31:0] CLRV  = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_write_enable = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [DW-1:0] i_write_data = '0;
  logic [3:0]    i_byte_enable = '0;
  logic          i_clear = 1'b0;
  logic          o_read_valid;
  logic [DW-1:0] o_read_data;
  logic          o_init_done;

  always #5 clk = ~clk;

  generic_sram_byte_en_clr #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(LAT), .CLEAR_VALUE(CLRV)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_write_enable(i_write_enable), .i_address(i_address), .i_write_data(i_write_data),
    .i_byte_enable(i_byte_enable), .i_clear(i_clear), .o_read_valid(o_read_valid),
    .o_read_data(o_read_data), .o_init_done(o_init_done)
  );

  // Reference model: memory contents, remaining clear cycles, and a list of
  // pending read results tagged with the cycle they must appear.
  typedef struct { int due; logic [31:0] d; } rd_t;
  logic [31:0] mem_m [DEPTH];
  rd_t         pend[$];
  int          busy = DEPTH;
  int          cyc = 0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_rdata = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic clr, input logic rst_in);
    rd_t r;
    i_req_valid = v; i_write_enable = we; i_address = a; i_write_data = d;
    i_byte_enable = be; i_clear = clr; i_rst = rst_in;
    @(posedge clk);
    cyc++;
    if (rst_in) begin
      busy = DEPTH;
      pend.delete();
      exp_rdata = '0;
    end else if (busy > 0) begin
      mem_m[DEPTH-busy] = CLRV;
      busy--;
    end else begin
      if (v && !we) begin
        r.due = cyc + LAT - 1;
        r.d   = mem_m[a];
        pend.push_back(r);
      end
      if (v && we) begin
        for (int k = 0; k < 4; k++) if (be[k]) mem_m[a][8*k +: 8] = d[8*k +: 8];
      end
      if (clr) busy = DEPTH;
    end
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_rdata = pend[0].d;
      pend.delete(0);
    end
    #1;
    chk("req_ready", 32'(o_req_ready), 32'(busy == 0));
    chk("init_done", 32'(o_init_done), 32'(busy == 0));
    chk("read_valid", 32'(o_read_valid), 32'(exp_valid));
    chk("read_data", o_read_data, exp_rdata);
  endtask

  task automatic idle_step(input logic rst_in);
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, rst_in);
  endtask

  // Counts idle cycles until o_req_ready is seen high (bounded).
  task automatic wait_ready(input int exp_n, input string nm);
    int n;
    n = 0;
    while (o_req_ready !== 1'b1 && n < 64) begin
      idle_step(1'b0);
      n++;
    end
    chk(nm, 32'(n), 32'(exp_n));
  endtask

  typedef struct {
    logic v; logic we; logic [3:0] a; logic [31:0] d; logic [3:0] be;
    logic ev; logic [31:0] ed;
  } vec_t;
  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'd3, 32'h11223344, 4'hF, 1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b1, 4'd3, 32'hAABBCCDD, 4'h5, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b1, 4'd0, 32'h0A0A0A0A, 4'hF, 1'b0, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b1, 4'd2, 32'h22222222, 4'hF, 1'b0, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b1, 4'd1, 32'hFFFFFFFF, 4'h0, 1'b0, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 1'b0, 4'd3, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 32'h11BB33DD};
    tbl[7]  = '{1'b1, 1'b0, 4'd1, 32'h0,        4'h0, 1'b1, 32'h0A0A0A0A};
    tbl[8]  = '{1'b1, 1'b0, 4'd2, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    tbl[9]  = '{1'b1, 1'b1, 4'd5, 32'h00000055, 4'hF, 1'b1, 32'h22222222};
    tbl[10] = '{1'b1, 1'b0, 4'd5, 32'h0,        4'h0, 1'b0, 32'h22222222};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 32'h00000055};
    tbl[12] = '{1'b0, 1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 32'h00000055};

    // Reset, then initial clear: ready first seen after 16 cycles.
    idle_step(1'b1);
    idle_step(1'b1);
    wait_ready(16, "init_ready_rise");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 4'(i), 32'd0, 4'd0, 1'b0, 1'b0);
    idle_step(1'b0);
    idle_step(1'b0);

    // Byte-merge, be=0 write, back-to-back reads, read-after-write.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(o_read_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), o_read_data, tbl[i].ed);
    end

    // Read accepted together with i_clear delivers pre-clear data.
    step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b1, 1'b0);
    idle_step(1'b0);
    chk("clr_read_valid", 32'(o_read_valid), 32'd1);
    chk("clr_read_data", o_read_data, 32'h00000055);
    wait_ready(15, "clr_ready_rise");
    step(1'b1, 1'b0, 4'd5, 32'd0, 4'd0, 1'b0, 1'b0);
    idle_step(1'b0);
    chk("post_clr_data", o_read_data, CLRV);

    // Reset with a read in flight, then reset again at clear cycle 7.
    step(1'b1, 1'b0, 4'd3, 32'd0, 4'd0, 1'b1, 1'b0);
    idle_step(1'b1);
    chk("rst_valid", 32'(o_read_valid), 32'd0);
    chk("rst_data", o_read_data, 32'd0);
    chk("rst_init_done", 32'(o_init_done), 32'd0);
    for (int i = 0; i < 7; i++) idle_step(1'b0);
    idle_step(1'b1);
    chk("rst7_init_done", 32'(o_init_done), 32'd0);
    wait_ready(16, "rst7_ready_rise");

    // i_clear during a clear does not restart it.
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle_step(1'b0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    wait_ready(10, "clr_in_clear_rise");

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 63) == 0),
           1'($urandom_range(0, 249) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/generic_sram_byte_en_clr.md
Name: generic_sram_byte_en_clr

Overview:
Single-port, byte-enabled synchronous SRAM with a built-in clear sequencer, a valid/ready request handshake, and a selectable read latency of 1 or 2 cycles. After reset, and on request, the block fills every word with CLEAR_VALUE before it accepts traffic. This removes the need for init files or software scrubbing. It replaces the plain byte-enable SRAM in caches and tag stores that need a known-clean state at boot and on flush.

Parameters:
DATA_WIDTH, 128, word width in bits; must be a multiple of 8.
ADDRESS_WIDTH, 7, address bits; depth N = 2^ADDRESS_WIDTH.
READ_LATENCY, 1, cycles from accepted read to o_read_valid; legal values 1 or 2; any other value is an elaboration error.
CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every address during a clear.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_req_valid  in  1  request present.
o_req_ready  out  1  block can accept a request.
i_write_enable  in  1  1 = write, 0 = read; sampled with the request.
i_address  in  ADDRESS_WIDTH  word address.
i_write_data  in  DATA_WIDTH  write data.
i_byte_enable  in  DATA_WIDTH/8  per-byte write mask; bit k covers bits [8k+7:8k].
i_clear  in  1  single-cycle pulse; starts a full clear.
o_read_valid  out  1  o_read_data is valid this cycle; single-cycle pulse per read.
o_read_data  out  DATA_WIDTH  read data.
o_init_done  out  1  high once a clear has completed and no clear is running.

Behaviour:
- Storage is a behavioural array of N x DATA_WIDTH, written so that synthesis infers block RAM.
- Reset values: o_req_ready=0, o_init_done=0, o_read_valid=0, o_read_data=0. Clear counter=0, FSM=CLEAR, read pipeline valids=0.
- FSM has two states, CLEAR and IDLE.
- CLEAR state:
  - Each cycle, write CLEAR_VALUE (all bytes) to address clr_cnt, then increment clr_cnt.
  - After the write to N-1, go to IDLE and set o_init_done=1 and o_req_ready=1.
  - Cycle 0 is the first edge with i_rst low. Addresses 0..N-1 are written on cycles 0..N-1, and o_req_ready is high from cycle N.
  - In CLEAR, o_req_ready=0 and requests are ignored.
  - i_clear during CLEAR is ignored; the clear does not restart.
- IDLE state:
  - A request is accepted when i_req_valid && o_req_ready.
  - An accepted write updates only the bytes whose i_byte_enable bit is 1. A write with i_byte_enable=0 leaves memory unchanged.
  - An accepted read causes o_read_valid to pulse exactly READ_LATENCY cycles later, with the array contents at the time of acceptance.
  - Back-to-back reads are accepted every cycle, and o_read_valid follows with the same spacing.
  - A read immediately after a write to the same address returns the newly written data (merged bytes).
  - Writes never produce o_read_valid.
- o_read_data holds its last value between valid pulses. With READ_LATENCY=2, the array read is registered once and the output is registered again.
- i_clear in IDLE:
  - The next cycle, o_req_ready=0, o_init_done=0, the FSM enters CLEAR and clr_cnt=0.
  - A request accepted in the same cycle as i_clear completes before the clear starts.
  - Reads already in the pipeline still deliver o_read_valid with pre-clear data.
- Reset asserted mid-operation (during a clear or with reads in flight): all pending valids are dropped, outputs return to their reset values, and a full clear restarts after release.
- No wrap or overflow beyond clr_cnt. clr_cnt is ADDRESS_WIDTH+1 bits wide so that the terminal count is detected unambiguously.

Test Plan:
1. ADDRESS_WIDTH=4, CLEAR_VALUE=32'hDEADBEEF, DATA_WIDTH=32; release reset -> o_req_ready and o_init_done rise in cycle 16 and stay 0 in cycles 0..15; reads of addresses 0..15 all return 32'hDEADBEEF.
2. After init, write addr 3 data 32'h11223344 be=4'b1111, then write addr 3 data 32'hAABBCCDD be=4'b0101, then read addr 3 -> o_read_data=32'h11BB33DD. o_read_valid is 1 cycle after the read when READ_LATENCY=1 and 2 cycles after when READ_LATENCY=2.
3. Back-to-back reads of addresses 0,1,2 on consecutive cycles with READ_LATENCY=2 -> three consecutive o_read_valid pulses starting 2 cycles after the first read, with data in address order. A write with be=0 to address 1 beforehand leaves its contents unchanged.
4. Read addr 5 (holding 32'h55) accepted in the same cycle as the i_clear pulse -> o_read_valid with 32'h55 at the expected latency; o_req_ready is low for the next 16 cycles; a subsequent read of addr 5 returns CLEAR_VALUE.
5. Assert i_rst for 1 cycle at clear cycle 7 with a read in flight -> no o_read_valid, o_read_data=0, o_init_done=0; after release, init completes 16 cycles later.
6. Pulse i_clear while already in CLEAR -> the clear is not restarted and o_init_done rises at the original cycle.
